hog_block_buffer: RTL and testbench

//  Upstream neighbour of the svm stage.

---
 rtl/hog_pkg.sv | 22 ++
 rtl/cell_line_buffer.sv | 32 +++
 rtl/hog_block_buffer.sv | 123 ++++++++++++
 tb/tb_hog_block_buffer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hog_pkg.sv
// Shared types and constants for the HOG block-forming stage that feeds the svm.
package hog_pkg;

    localparam int unsigned FEA_I  = 4;
    localparam int unsigned FEA_F  = 28;
    localparam int unsigned FEA_W  = FEA_I + FEA_F;
    localparam int unsigned BIN_N  = 9;
    localparam int unsigned CELL_W = FEA_W * BIN_N;

    typedef logic [CELL_W-1:0] cell_hist_t;

    typedef enum logic {
        FIRST_ROW,
        STREAM
    } blk_state_e;

    // Index width that never collapses to zero bits for tiny ranges.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cell_line_buffer.sv
// One cell row of histograms; single-port read-first RAM with a registered read port.
module cell_line_buffer #(
    parameter int unsigned WIDTH  = hog_pkg::CELL_W,
    parameter int unsigned DEPTH  = 80,
    parameter int unsigned ADDR_W = hog_pkg::idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wdata;
        end
    end

    // Old contents are captured on the same edge that overwrites them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/hog_block_buffer.sv
// Turns a raster stream of cell histograms into overlapping 2x2 blocks for the svm.
module hog_block_buffer #(
    parameter int unsigned FEA_I     = 4,
    parameter int unsigned FEA_F     = 28,
    parameter int unsigned BIN_N     = 9,
    parameter int unsigned CELL_COLS = 80,
    parameter int unsigned CELL_ROWS = 60
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             i_sof,
    input  logic                                             i_valid,
    input  logic [(FEA_I+FEA_F)*BIN_N-1:0]                   cell_hist,
    output logic [(FEA_I+FEA_F)*BIN_N-1:0]                   fea_a,
    output logic [(FEA_I+FEA_F)*BIN_N-1:0]                   fea_b,
    output logic [(FEA_I+FEA_F)*BIN_N-1:0]                   fea_c,
    output logic [(FEA_I+FEA_F)*BIN_N-1:0]                   fea_d,
    output logic                                             o_valid,
    output logic [hog_pkg::idx_width(CELL_COLS-1)-1:0]       blk_col,
    output logic [hog_pkg::idx_width(CELL_ROWS-1)-1:0]       blk_row
);

    import hog_pkg::*;

    localparam int unsigned CW      = (FEA_I + FEA_F) * BIN_N;
    localparam int unsigned COL_W   = idx_width(CELL_COLS);
    localparam int unsigned ROW_W   = idx_width(CELL_ROWS);
    localparam int unsigned BCOL_W  = idx_width(CELL_COLS - 1);
    localparam int unsigned BROW_W  = idx_width(CELL_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(CELL_COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(CELL_ROWS - 1);

    blk_state_e       state_q, state_d, state_cur;
    logic [COL_W-1:0] col_q, col_d, cur_col;
    logic [ROW_W-1:0] row_q, row_d, cur_row;
    logic             last_col, last_cell, emit;
    logic [CW-1:0]    top_old, cur_q, fea_b_hold;

    cell_line_buffer #(
        .WIDTH  (CW),
        .DEPTH  (CELL_COLS),
        .ADDR_W (COL_W)
    ) u_line_buf (
        .clk   (clk),
        .rst   (rst),
        .en    (i_valid),
        .addr  (cur_col),
        .wdata (cell_hist),
        .rdata (top_old)
    );

    // A start-of-frame beat overrides the counters and the FSM as cell (0,0).
    always_comb begin
        cur_col   = i_sof ? '0 : col_q;
        cur_row   = i_sof ? '0 : row_q;
        state_cur = i_sof ? FIRST_ROW : state_q;
        last_col  = (cur_col == LAST_COL);
        last_cell = last_col && (cur_row == LAST_ROW);
        emit      = i_valid && (state_cur == STREAM) && (cur_col != '0);
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        if (i_valid) begin
            col_d = last_col ? '0 : cur_col + 1'b1;
            if (last_col) begin
                row_d = last_cell ? '0 : cur_row + 1'b1;
            end else begin
                row_d = cur_row;
            end
            unique case (state_cur)
                FIRST_ROW: state_d = last_col ? STREAM : FIRST_ROW;
                STREAM:    state_d = last_cell ? FIRST_ROW : STREAM;
                default:   state_d = FIRST_ROW;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FIRST_ROW;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Between beats the RAM output still holds the previous beat's top cell,
    // so it serves directly as the top-left neighbour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid    <= 1'b0;
            fea_a      <= '0;
            fea_c      <= '0;
            fea_d      <= '0;
            blk_col    <= '0;
            blk_row    <= '0;
            cur_q      <= '0;
            fea_b_hold <= '0;
        end else begin
            o_valid <= emit;
            if (i_valid) begin
                cur_q <= cell_hist;
            end
            if (emit) begin
                fea_a   <= top_old;
                fea_c   <= cur_q;
                fea_d   <= cell_hist;
                blk_col <= BCOL_W'(cur_col - 1'b1);
                blk_row <= BROW_W'(cur_row - 1'b1);
            end
            if (o_valid) begin
                fea_b_hold <= top_old;
            end
        end
    end

    // The top-right cell only exists at the RAM port during the valid cycle.
    assign fea_b = o_valid ? top_old : fea_b_hold;

endmodule

// File: tb/tb_hog_block_buffer.sv
// Scoreboard bench for hog_block_buffer on a 4x3-cell frame.
module tb_hog_block_buffer;

    localparam int unsigned COLS = 4;
    localparam int unsigned ROWS = 3;
    localparam int unsigned CW   = 288;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_sof = 1'b0;
    logic          i_valid = 1'b0;
    logic [CW-1:0] cell_hist = '0;
    logic [CW-1:0] fea_a, fea_b, fea_c, fea_d;
    logic          o_valid;
    logic [1:0]    blk_col;
    logic [0:0]    blk_row;

    hog_block_buffer #(
        .FEA_I     (4),
        .FEA_F     (28),
        .BIN_N     (9),
        .CELL_COLS (COLS),
        .CELL_ROWS (ROWS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_sof     (i_sof),
        .i_valid   (i_valid),
        .cell_hist (cell_hist),
        .fea_a     (fea_a),
        .fea_b     (fea_b),
        .fea_c     (fea_c),
        .fea_d     (fea_d),
        .o_valid   (o_valid),
        .blk_col   (blk_col),
        .blk_row   (blk_row)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fa;
        int fb;
        int fc;
        int fd;
        int bc;
        int br;
        int cyc;
    } exp_t;

    typedef struct {
        string name;
        int    gap;
        int    frames;
        int    cut_after;
        bit    do_rst;
        int    exp_blocks;
    } scen_t;

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            neg_cnt  = 0;
    int            blk_cnt  = 0;
    logic [CW-1:0] hold_a = '0, hold_b = '0, hold_c = '0, hold_d = '0;

    function automatic logic [CW-1:0] mk(int v);
        logic [31:0] w;
        w = v;
        return {9{w}};
    endfunction

    // Monitor: pops the scoreboard on every pulse, flags late or spurious pulses,
    // checks reset values and that the data outputs hold between pulses.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            hold_a = '0; hold_b = '0; hold_c = '0; hold_d = '0;
            n_checks++;
            if (o_valid !== 1'b0 || fea_a !== '0 || fea_b !== '0 || fea_c !== '0 ||
                fea_d !== '0 || blk_col !== '0 || blk_row !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: o_valid=%b a=%0d b=%0d c=%0d d=%0d col=%0d row=%0d, need all 0",
                         o_valid, fea_a[31:0], fea_b[31:0], fea_c[31:0], fea_d[31:0],
                         blk_col, blk_row);
            end
        end else if (o_valid === 1'b1) begin
            blk_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_block: got a=%0d b=%0d c=%0d d=%0d col=%0d row=%0d at cycle %0d, none expected",
                         fea_a[31:0], fea_b[31:0], fea_c[31:0], fea_d[31:0], blk_col, blk_row,
                         neg_cnt);
            end else begin
                e = exp_q.pop_front();
                if (fea_a !== mk(e.fa) || fea_b !== mk(e.fb) || fea_c !== mk(e.fc) ||
                    fea_d !== mk(e.fd) || blk_col !== 2'(e.bc) || blk_row !== 1'(e.br) ||
                    e.cyc != neg_cnt) begin
                    n_fail++;
                    $display("FAIL block: got a=%0d b=%0d c=%0d d=%0d col=%0d row=%0d cyc=%0d, need a=%0d b=%0d c=%0d d=%0d col=%0d row=%0d cyc=%0d",
                             fea_a[31:0], fea_b[31:0], fea_c[31:0], fea_d[31:0], blk_col, blk_row,
                             neg_cnt, e.fa, e.fb, e.fc, e.fd, e.bc, e.br, e.cyc);
                end
                hold_a = mk(e.fa); hold_b = mk(e.fb); hold_c = mk(e.fc); hold_d = mk(e.fd);
            end
        end else begin
            if (exp_q.size() > 0 && exp_q[0].cyc <= neg_cnt) begin
                e = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_block: o_valid=0 at cycle %0d, need block col=%0d row=%0d",
                         neg_cnt, e.bc, e.br);
            end
            n_checks++;
            if (fea_a !== hold_a || fea_b !== hold_b || fea_c !== hold_c || fea_d !== hold_d) begin
                n_fail++;
                $display("FAIL hold: got a=%0d b=%0d c=%0d d=%0d, need a=%0d b=%0d c=%0d d=%0d",
                         fea_a[31:0], fea_b[31:0], fea_c[31:0], fea_d[31:0],
                         hold_a[31:0], hold_b[31:0], hold_c[31:0], hold_d[31:0]);
            end
        end
        neg_cnt++;
    end

    // Called just after a rising edge; the beat is accepted on the next one.
    // Blocks come from the raster enumeration of 2x2 windows ending at (r,c).
    task automatic send(input int r, input int c, input bit sof);
        exp_t e;
        i_valid   = 1'b1;
        i_sof     = sof;
        cell_hist = mk(r * COLS + c);
        if (r >= 1 && c >= 1) begin
            e.fa  = (r - 1) * COLS + c - 1;
            e.fb  = (r - 1) * COLS + c;
            e.fc  = r * COLS + c - 1;
            e.fd  = r * COLS + c;
            e.bc  = c - 1;
            e.br  = r - 1;
            e.cyc = neg_cnt + 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_sof   = 1'b0;
    endtask

    task automatic drive_frame(input int gap, input bit sof, input int cut_after);
        int k;
        k = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                repeat (gap > 0 ? $urandom_range(0, gap) : 0) begin
                    @(posedge clk);
                    #1;
                end
                send(r, c, sof && r == 0 && c == 0);
                if (k == cut_after) return;
                k++;
            end
        end
    endtask

    scen_t scen[5];

    initial begin
        scen[0] = '{"continuous",   0, 1, -1, 1'b0, 6};
        scen[1] = '{"random_gaps",  3, 1, -1, 1'b0, 6};
        scen[2] = '{"back_to_back", 0, 2, -1, 1'b0, 12};
        scen[3] = '{"sof_mid_row",  0, 1,  6, 1'b0, 8};
        scen[4] = '{"reset_mid",    0, 1,  5, 1'b1, 6};

        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int s = 0; s < 5; s++) begin
            blk_cnt = 0;
            if (scen[s].cut_after >= 0) begin
                drive_frame(scen[s].gap, 1'b1, scen[s].cut_after);
            end
            if (scen[s].do_rst) begin
                rst = 1'b0;
                exp_q.delete();
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
            end
            drive_frame(scen[s].gap, 1'b1, -1);
            for (int f = 1; f < scen[s].frames; f++) begin
                drive_frame(scen[s].gap, 1'b0, -1);
            end
            repeat (4) begin
                @(posedge clk);
                #1;
            end
            n_checks++;
            if (blk_cnt != scen[s].exp_blocks || exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL %s block_count: got %0d blocks (%0d still pending), need %0d",
                         scen[s].name, blk_cnt, exp_q.size(), scen[s].exp_blocks);
                exp_q.delete();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
